// File: rtl/microwave_countdown_timer_pkg.sv
// Shared types and constants for the microwave countdown timer: FSM states,
// BCD limits and the three-digit cook time with its borrow-chain decrement.
package microwave_countdown_timer_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_WRAP = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    typedef struct packed {
        bcd_t min;
        bcd_t tens;
        bcd_t ones;
    } cook_time_t;

    // Borrow into sec_tens wraps to 5, not 9: the display is m:ss.
    function automatic cook_time_t bcd_decrement(input cook_time_t t);
        cook_time_t r;
        r = t;
        if (t.ones != '0) begin
            r.ones = t.ones - bcd_t'(1);
        end else begin
            r.ones = BCD_MAX;
            if (t.tens != '0) begin
                r.tens = t.tens - bcd_t'(1);
            end else begin
                r.tens = SEC_TENS_WRAP;
                r.min  = t.min - bcd_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/microwave_countdown_timer_sec_prescaler.sv
// One-second prescaler: counts enabled cycles and pulses tick on the wrap cycle.
// The count is held (not cleared) while disabled so a paused run resumes mid-second.
module microwave_countdown_timer_sec_prescaler #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/microwave_countdown_timer.sv
// Microwave cook-time controller: keypad BCD entry, start/stop/pause, door
// interlock and a once-per-second countdown driving the 7-segment decoder.
module microwave_countdown_timer
    import microwave_countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int CNT_W         = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_valid,
    input  logic [BCD_W-1:0] digit,
    input  logic             start,
    input  logic             stop,
    input  logic             door_closed,
    output logic [BCD_W-1:0] min,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             done
);

    state_t     state;
    cook_time_t tm;
    cook_time_t tm_dec;
    logic       tick;
    logic       presc_en;
    logic       presc_clr;

    // stop and door-open outrank the tick, so the prescaler must not advance then.
    assign presc_en  = (state == ST_RUN) && !stop && door_closed;
    assign presc_clr = (state == ST_IDLE) || ((state == ST_PAUSED) && stop);
    assign tm_dec    = bcd_decrement(tm);

    microwave_countdown_timer_sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .CNT_W        (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .enable(presc_en),
        .clear (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tm      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (stop) begin
                        tm <= '0;
                    end else if (start && door_closed && (tm != '0)) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else if (digit_valid && (digit <= BCD_MAX)) begin
                        tm <= {tm.tens, tm.ones, digit};
                    end
                end
                ST_RUN: begin
                    if (stop || !door_closed) begin
                        state   <= ST_PAUSED;
                        running <= 1'b0;
                    end else if (tick) begin
                        tm <= tm_dec;
                        if (tm_dec == '0) begin
                            state   <= ST_IDLE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        tm    <= '0;
                    end else if (start && door_closed) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign min      = tm.min;
    assign sec_tens = tm.tens;
    assign sec_ones = tm.ones;

endmodule
